// File: rtl/time_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_frame_pkg
// Description : ASCII constants, frame length helper and state type for the
//               time-to-UART frame serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package time_frame_pkg;

  localparam logic [7:0] SPACE   = 8'h20;
  localparam logic [7:0] COLON   = 8'h3A;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] QMARK   = 8'h3F;
  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_L = 8'h4C;
  localparam logic [7:0] ASCII_S = 8'h53;
  localparam logic [7:0] ASCII_W = 8'h57;

  // prefix(2) + space + 2 digits per field + colons between fields + CR/LF
  function automatic int frame_len(input int num_fields);
    return 3 * num_fields + 4;
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/time_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : time_frame_tx_if
// Description : Character stream (valid/ready) towards the UART TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface time_frame_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/time_frame_tx_bcd_to_ascii.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_ascii
// Description : One BCD nibble to its ASCII digit; non-decimal codes give '?'.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_ascii
  import time_frame_pkg::*;
(
  input  wire logic [3:0] nibble,
  output logic      [7:0] ascii
);

  assign ascii = (nibble <= 4'd9) ? (8'h30 | {4'h0, nibble}) : QMARK;

endmodule
`default_nettype wire

// File: rtl/time_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : time_frame_tx
// Description : Snapshots a packed BCD time on a trigger and streams it as an
//               ASCII line ("CL hh:mm:ss\r\n") over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module time_frame_tx
  import time_frame_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_FIELDS     = 3,
  parameter int SEND_ON_CHANGE = 0,
  parameter int DROP_W         = 8
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    trig,
  input  wire logic                    sw_mode,
  input  wire logic [8*NUM_FIELDS-1:0] time_bcd,
  time_frame_tx_if.master              tx,
  output logic                         busy,
  output logic                         frame_done,
  output logic      [DROP_W-1:0]       drop_cnt
);

  localparam int FRAME_LEN = frame_len(NUM_FIELDS);
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int SNAP_W    = 8 * NUM_FIELDS;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [SNAP_W-1:0]     r_snap;
  logic                  r_mode;
  logic                  r_sent;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  logic              w_hs;
  logic              w_last;
  logic              w_final;
  logic              w_changed;
  logic              w_accept;
  logic              w_capture;
  logic              w_drop;
  logic [IDX_W-1:0]  w_char_idx;
  logic [SNAP_W-1:0] w_sel_bcd;
  logic              w_sel_mode;
  int                w_pos;
  int                w_field;
  int                w_shamt;
  logic [3:0]        w_nibble;
  logic [7:0]        w_digit;
  logic [7:0]        w_char;

  assign w_hs      = r_valid & tx.tx_ready;
  assign w_last    = (r_idx == IDX_W'(FRAME_LEN - 1));
  assign w_final   = (r_state == SEND) & w_hs & w_last;
  assign w_changed = ~r_sent | ({sw_mode, time_bcd} != {r_mode, r_snap});
  assign w_accept  = trig & ((SEND_ON_CHANGE == 0) | w_changed);
  assign w_capture = w_accept & ((r_state == IDLE) | w_final);
  assign w_drop    = trig & (r_state == SEND) & ~w_final;

  // The output register is loaded with the character for the index it is
  // about to hold, taken from the snapshot it is about to hold.
  assign w_char_idx = w_capture ? '0 : r_idx + IDX_W'(1);
  assign w_sel_bcd  = w_capture ? time_bcd : r_snap;
  assign w_sel_mode = w_capture ? sw_mode : r_mode;

  // Body positions repeat as (tens, units, colon) per field, MS field first.
  always_comb begin
    w_pos   = int'(w_char_idx) - 3;
    w_field = 0;
    w_shamt = 0;
    if (w_pos >= 0 && w_pos < 3 * NUM_FIELDS) begin
      w_field = NUM_FIELDS - 1 - (w_pos / 3);
      w_shamt = 8 * w_field + (((w_pos % 3) == 0) ? 4 : 0);
    end
    w_nibble = 4'(w_sel_bcd >> w_shamt);
  end

  bcd_to_ascii u_digit (
    .nibble (w_nibble),
    .ascii  (w_digit)
  );

  always_comb begin
    w_char = w_digit;
    if (w_char_idx == IDX_W'(0))
      w_char = w_sel_mode ? ASCII_C : ASCII_S;
    else if (w_char_idx == IDX_W'(1))
      w_char = w_sel_mode ? ASCII_L : ASCII_W;
    else if (w_char_idx == IDX_W'(2))
      w_char = SPACE;
    else if (w_char_idx == IDX_W'(FRAME_LEN - 2))
      w_char = CR;
    else if (w_char_idx == IDX_W'(FRAME_LEN - 1))
      w_char = LF;
    else if ((w_pos % 3) == 2)
      w_char = COLON;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
      r_sent     <= 1'b0;
      r_snap     <= '0;
      r_mode     <= 1'b0;
    end else begin
      frame_done <= w_final;
      if (w_drop && (drop_cnt != '1))
        drop_cnt <= drop_cnt + DROP_W'(1);
      if (w_capture) begin
        r_snap <= time_bcd;
        r_mode <= sw_mode;
        r_sent <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_state <= SEND;
            r_valid <= 1'b1;
            busy    <= 1'b1;
            r_idx   <= '0;
            r_data  <= DATA_WIDTH'(w_char);
          end
        end
        SEND: begin
          if (w_hs) begin
            if (w_last && !w_capture) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              busy    <= 1'b0;
              r_idx   <= '0;
              r_data  <= '0;
            end else begin
              r_idx  <= w_char_idx;
              r_data <= DATA_WIDTH'(w_char);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx.tx_data  = r_data;
  assign tx.tx_valid = r_valid;

endmodule
`default_nettype wire

// File: doc/time_frame_tx.md
# time_frame_tx

Parametrised time-to-UART frame serializer: snapshots a packed BCD time value on a trigger and streams it as an ASCII text line ("CL 12:34:56\r\n" / "SW 00:01:07\r\n") to the UART TX FIFO over a valid/ready handshake. It sits between the clock/stopwatch counters and the UART transmitter. It generalises the fixed 13-character mux of the previous generation in four ways:
- configurable field count;
- tear-free snapshot;
- back-pressure;
- optional send-on-change and dropped-trigger accounting.

## Interface
- DATA_WIDTH, 8, character width on tx_data (ASCII in low 8 bits, upper bits zero)
- NUM_FIELDS, 3, number of 2-digit time fields, 1..4, most significant first (e.g. 4 = hh:mm:ss:cc)
- SEND_ON_CHANGE, 0, 1 = a trigger starts a frame only if the snapshot differs from the last sent frame
- DROP_W, 8, width of the saturating dropped-trigger counter

- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-low reset
- trig  in  1  one-cycle frame request (e.g. 100 Hz tick)
- sw_mode  in  1  1 = clock, prefix "CL"; 0 = stopwatch, prefix "SW"
- time_bcd  in  8*NUM_FIELDS  packed BCD, field k at [8k+7:8k], field NUM_FIELDS-1 sent first; tens nibble high
- tx_data  out  DATA_WIDTH  current character
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  sink accepts the character when tx_valid & tx_ready
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last character is accepted
- drop_cnt  out  DROP_W  triggers lost while busy, saturating

## Operation
- Frame length: FRAME_LEN = 3*NUM_FIELDS + 4.
  - Prefix, 2 characters.
  - Space 0x20.
  - Per field: tens digit, then units digit.
  - 0x3A between fields.
  - CR 0x0D, then LF 0x0A.
  - NUM_FIELDS=3 gives 13 characters.
- Digit encoding:
  - Nibble 0..9 maps to 0x30+n.
  - Nibble 0xA..0xF maps to '?' (0x3F).
- States:
  - IDLE: tx_valid=0, busy=0. An accepted trig captures time_bcd and sw_mode into the snapshot registers, sets idx=0, and goes to SEND.
  - SEND: tx_valid=1, busy=1. tx_data = char(idx) from the snapshot only; live inputs are ignored. On handshake, idx increments.
  - On handshake at idx=FRAME_LEN-1: frame_done pulses next cycle. If trig is high in that same cycle, a new snapshot is taken, idx=0 and the block stays in SEND (back-to-back, tx_valid stays 1). Otherwise the block goes to IDLE.
- Trigger acceptance:
  - SEND_ON_CHANGE=0: any trig in IDLE is accepted.
  - SEND_ON_CHANGE=1: trig is accepted only if {sw_mode,time_bcd} differs from the last-sent snapshot, or no frame has been sent since reset. A suppressed trig is not a drop.
- Drops:
  - A trig in SEND, other than on the final-handshake cycle, is dropped.
  - drop_cnt increments and saturates at 2^DROP_W-1.
  - drop_cnt is cleared only by reset.
- Hold rule: while tx_valid & !tx_ready, tx_data and idx are held stable.

## Timing
- Reset (rst=0 at a clk edge) gives:
  - state IDLE, idx=0, tx_valid=0, tx_data=0, busy=0, frame_done=0, drop_cnt=0.
  - sent-flag cleared.
- Reset mid-frame aborts the frame with no partial CR/LF; the sink sees tx_valid fall on the cycle after the reset edge.
- Latency: trig at edge N gives tx_valid=1 with the prefix first character at edge N+1.
- Full-rate sink (tx_ready=1): one character per cycle, so frame_done pulses at edge N+1+FRAME_LEN.
- tx_data and tx_valid are registered outputs; no combinational path from tx_ready to tx_valid.
- idx width: $clog2(FRAME_LEN).

## Structure
- Package time_frame_pkg:
  - ASCII constants: SPACE, COLON, CR, LF, QMARK, "C", "L", "S", "W".
  - Function frame_len(num_fields).
  - State enum {IDLE, SEND}.
- Sub-module bcd_to_ascii (4-bit nibble to 8-bit ASCII, '?' for >9), instantiated once on a nibble selected from the snapshot by idx.
- Character selection:
  - idx decodes to {prefix, space, tens, units, colon, CR, LF}.
  - Field and nibble index are computed arithmetically from idx, not from a NUM_FIELDS-specific case list.

## Test plan
- NUM_FIELDS=3, sw_mode=1, time_bcd=0x123456, tx_ready=1, trig pulse: exactly 13 characters 43 4C 20 31 32 3A 33 34 3A 35 36 0D 0A on consecutive cycles, then one frame_done pulse, then busy=0.
- Back-pressure: tx_ready toggled pseudo-randomly and time_bcd changed mid-frame: tx_data held while stalled, and the frame reflects the original snapshot only.
- Trig every cycle with tx_ready=1: frames run back-to-back with no tx_valid gap. drop_cnt increases by 12 per 13-cycle frame; with DROP_W=4 it saturates at 15.
- SEND_ON_CHANGE=1, time_bcd held at 0x000107 with 5 trigs spaced past each frame's end: only the first produces a frame and drop_cnt stays 0. Changing to 0x000108 and triggering produces a new frame.
- NUM_FIELDS=4, sw_mode=0, time_bcd=0x0001079A: the frame is "SW 00:01:07:9?\r\n" (16 characters).
- rst=0 asserted at idx=5: on the next cycle all outputs are 0. After release, a trig produces a complete fresh frame starting from the prefix.
